// File: rtl/traffic_pkg.sv
// Shared definitions for the N-way traffic light controller: lamp codes,
// FSM state encoding, phase counter width and a phase-length helper.
package traffic_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  localparam int PH_W = 8;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    WALK    = 2'd3
  } state_t;

  // Terminal count of a phase lasting dur ticks; a length of 0 acts as 1.
  function automatic logic [PH_W-1:0] phaseLast(input int dur);
    if (dur <= 1) begin
      return '0;
    end
    return PH_W'(dur - 1);
  endfunction

endpackage

// File: rtl/traffic_ctrl_nway_sec_tick_gen.sv
// Seconds prescaler: counts 0..CLK_DIV-1 and flags the last count of each
// wrap as a one-cycle tick.
module sec_tick_gen #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic sec_tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Wrap back to zero after the last count, otherwise step by one.
  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
  end

  // Prescaler register, cleared by reset so the first tick is CLK_DIV cycles out.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign sec_tick_o = (count_q == LAST);

endmodule

// File: rtl/traffic_ctrl_nway.sv
// N-way intersection light controller with demand-driven direction skipping
// and green extension. Optional pedestrian all-red WALK phase is compiled in
// when the macro TRAFFIC_PED_EN is defined.
module traffic_ctrl_nway
  import traffic_pkg::*;
#(
  parameter int NUM_DIR     = 4,
  parameter int CLK_DIV     = 50000000,
  parameter int STARTUP_SEC = 1,
  parameter int GREEN_SEC   = 5,
  parameter int YELLOW_SEC  = 1,
  parameter int WALK_SEC    = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_DIR-1:0]           demand_i,
  output logic [2*NUM_DIR-1:0]         lights_o,
  output logic [$clog2(NUM_DIR)-1:0]   active_dir_o,
  output logic                         sec_tick_o
`ifdef TRAFFIC_PED_EN
  ,
  input  logic                         ped_req_i,
  output logic                         walk_o
`endif
);

  localparam int DW = $clog2(NUM_DIR);

  localparam logic [PH_W-1:0] STARTUP_LAST = phaseLast(STARTUP_SEC);
  localparam logic [PH_W-1:0] GREEN_LAST   = phaseLast(GREEN_SEC);
  localparam logic [PH_W-1:0] YELLOW_LAST  = phaseLast(YELLOW_SEC);
  localparam logic [PH_W-1:0] WALK_LAST    = phaseLast(WALK_SEC);

  state_t               state_q, state_d;
  logic [DW-1:0]        activeDir_q, activeDir_d;
  logic [DW-1:0]        nextDir_q, nextDir_d;
  logic [PH_W-1:0]      phaseCnt_q, phaseCnt_d;
  logic [2*NUM_DIR-1:0] lights_q, lights_d;
  logic                 secTick;
  logic [PH_W-1:0]      lastCnt;
  logic                 phaseEnd;
  logic                 illegal;
  logic                 rrFound;
  logic [DW-1:0]        rrDir;
  logic [DW-1:0]        incDir;
`ifdef TRAFFIC_PED_EN
  logic                 pedPending_q, pedPending_d;
  logic                 walk_q, walk_d;
  logic                 enterWalk;
`endif

  sec_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sec_tick_gen (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .sec_tick_o (secTick)
  );

  // Round-robin search for the first demanding direction after the active one.
  always_comb begin
    rrFound = 1'b0;
    rrDir   = '0;
    for (int i = 1; i < NUM_DIR; i++) begin
      int idx;
      idx = int'(activeDir_q) + i;
      if (idx >= NUM_DIR) begin
        idx = idx - NUM_DIR;
      end
      if (!rrFound && demand_i[idx]) begin
        rrFound = 1'b1;
        rrDir   = DW'(idx);
      end
    end
    incDir = (activeDir_q >= DW'(NUM_DIR - 1)) ? '0 : activeDir_q + DW'(1);
  end

  // Next-state logic, phase timing and registered lamp decode of the next state.
  always_comb begin
    state_d     = state_q;
    activeDir_d = activeDir_q;
    nextDir_d   = nextDir_q;
    illegal     = 1'b0;
`ifdef TRAFFIC_PED_EN
    enterWalk   = 1'b0;
`endif

    case (state_q)
      STARTUP: lastCnt = STARTUP_LAST;
      GREEN:   lastCnt = GREEN_LAST;
      YELLOW:  lastCnt = YELLOW_LAST;
      WALK:    lastCnt = WALK_LAST;
      default: lastCnt = '0;
    endcase
    phaseEnd = secTick && (phaseCnt_q == lastCnt);

    if (phaseEnd) begin
      phaseCnt_d = '0;
    end else if (secTick) begin
      phaseCnt_d = phaseCnt_q + PH_W'(1);
    end else begin
      phaseCnt_d = phaseCnt_q;
    end

    case (state_q)
      STARTUP: begin
        if (phaseEnd) begin
          state_d     = GREEN;
          activeDir_d = '0;
        end
      end
      GREEN: begin
        if (phaseEnd) begin
          if (rrFound) begin
            nextDir_d = rrDir;
            state_d   = YELLOW;
          end else if (!demand_i[activeDir_q]) begin
            nextDir_d = incDir;
            state_d   = YELLOW;
          end
        end
      end
      YELLOW: begin
        if (phaseEnd) begin
`ifdef TRAFFIC_PED_EN
          if (pedPending_q) begin
            state_d   = WALK;
            enterWalk = 1'b1;
          end else begin
            state_d     = GREEN;
            activeDir_d = nextDir_q;
          end
`else
          state_d     = GREEN;
          activeDir_d = nextDir_q;
`endif
        end
      end
`ifdef TRAFFIC_PED_EN
      WALK: begin
        if (phaseEnd) begin
          state_d     = GREEN;
          activeDir_d = nextDir_q;
        end
      end
`endif
      default: begin
        illegal     = 1'b1;
        state_d     = STARTUP;
        activeDir_d = '0;
        nextDir_d   = '0;
        phaseCnt_d  = '0;
      end
    endcase

    lights_d = {NUM_DIR{LAMP_RED}};
    if (!illegal) begin
      case (state_d)
        STARTUP: lights_d = {NUM_DIR{LAMP_YELLOW}};
        GREEN: begin
          for (int d = 0; d < NUM_DIR; d++) begin
            if (DW'(d) == activeDir_d) begin
              lights_d[2*d +: 2] = LAMP_GREEN;
            end
          end
        end
        YELLOW: begin
          for (int d = 0; d < NUM_DIR; d++) begin
            if (DW'(d) == activeDir_d || DW'(d) == nextDir_d) begin
              lights_d[2*d +: 2] = LAMP_YELLOW;
            end
          end
        end
        default: lights_d = {NUM_DIR{LAMP_RED}};
      endcase
    end

`ifdef TRAFFIC_PED_EN
    walk_d       = (state_d == WALK) && !illegal;
    pedPending_d = (pedPending_q && !enterWalk) || ped_req_i;
`endif
  end

  // Controller state registers; reset restarts from the all-yellow phase.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= STARTUP;
      activeDir_q <= '0;
      nextDir_q   <= '0;
      phaseCnt_q  <= '0;
      lights_q    <= {NUM_DIR{LAMP_YELLOW}};
    end else begin
      state_q     <= state_d;
      activeDir_q <= activeDir_d;
      nextDir_q   <= nextDir_d;
      phaseCnt_q  <= phaseCnt_d;
      lights_q    <= lights_d;
    end
  end

`ifdef TRAFFIC_PED_EN
  // Pedestrian request latch and walk lamp register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pedPending_q <= 1'b0;
      walk_q       <= 1'b0;
    end else begin
      pedPending_q <= pedPending_d;
      walk_q       <= walk_d;
    end
  end

  assign walk_o = walk_q;
`endif

  assign lights_o     = lights_q;
  assign active_dir_o = activeDir_q;
  assign sec_tick_o   = secTick;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed testbench for traffic_ctrl_nway: a 4-way and a 3-way instance
// share clock and reset; pedestrian checks are built with TRAFFIC_PED_EN.
module tb_traffic_ctrl_nway;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] demand4 = '0;
  logic [2:0] demand3 = '0;
  logic [7:0] lights4;
  logic [5:0] lights3;
  logic [1:0] activeDir4;
  logic [1:0] activeDir3;
  logic       secTick4;
  logic       secTick3;
`ifdef TRAFFIC_PED_EN
  logic       pedReq4 = 1'b0;
  logic       pedReq3 = 1'b0;
  logic       walk4;
  logic       walk3;
`endif

  int testsRun = 0;
  int failCount = 0;
  int cyc = 0;
  logic [1:0] maxDir3 = '0;

  always #5 clk = ~clk;

  traffic_ctrl_nway #(
    .NUM_DIR(4), .CLK_DIV(4), .STARTUP_SEC(2), .GREEN_SEC(3),
    .YELLOW_SEC(1), .WALK_SEC(2)
  ) dut4 (
    .clk_i        (clk),
    .reset_i      (reset),
    .demand_i     (demand4),
    .lights_o     (lights4),
    .active_dir_o (activeDir4),
    .sec_tick_o   (secTick4)
`ifdef TRAFFIC_PED_EN
    ,
    .ped_req_i    (pedReq4),
    .walk_o       (walk4)
`endif
  );

  traffic_ctrl_nway #(
    .NUM_DIR(3), .CLK_DIV(4), .STARTUP_SEC(2), .GREEN_SEC(3),
    .YELLOW_SEC(1), .WALK_SEC(2)
  ) dut3 (
    .clk_i        (clk),
    .reset_i      (reset),
    .demand_i     (demand3),
    .lights_o     (lights3),
    .active_dir_o (activeDir3),
    .sec_tick_o   (secTick3)
`ifdef TRAFFIC_PED_EN
    ,
    .ped_req_i    (pedReq3),
    .walk_o       (walk3)
`endif
  );

  // Track the largest direction index the 3-way controller ever reports.
  always @(negedge clk) begin
    if (!reset && activeDir3 > maxDir3) begin
      maxDir3 = activeDir3;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulse reset across one rising edge; leaves us sampling just after it.
  task automatic applyStimulus();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  // Advance to the falling edge that follows rising edge number target.
  task automatic runTo(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    // Reset state, prescaler start, rotation with no demand (4-way and 3-way).
    applyStimulus();
    maxDir3 = '0;
    checkOutput("rstLights4", lights4, 8'h55);
    checkOutput("rstDir4", activeDir4, 0);
    checkOutput("rstTick", secTick4, 0);
    checkOutput("rstLights3", lights3, 6'h15);
    runTo(2);  checkOutput("tickLow2", secTick4, 0);
    runTo(3);  checkOutput("tickFirst", secTick4, 1);
    runTo(4);  checkOutput("tickPulse", secTick4, 0);
    runTo(7);  checkOutput("startupEnd", lights4, 8'h55);
    runTo(8);  checkOutput("green0", lights4, 8'h02);
    runTo(19); checkOutput("green0Last", lights4, 8'h02);
    runTo(20); checkOutput("yellow01", lights4, 8'h05);
    checkOutput("yellowDir", activeDir4, 0);
    runTo(23); checkOutput("yellowLast", lights4, 8'h05);
    runTo(24); checkOutput("green1", lights4, 8'h08);
    checkOutput("dir1", activeDir4, 1);
    checkOutput("n3Dir1", activeDir3, 1);
    runTo(40); checkOutput("n3Dir2", activeDir3, 2);
    checkOutput("n3Green2", lights3, 6'h20);
    runTo(52); checkOutput("n3Yellow20", lights3, 6'h11);
    runTo(56); checkOutput("n3Wrap", activeDir3, 0);
    checkOutput("n3MaxDir", maxDir3, 2);

    // Skip directions 1 and 2 when only direction 3 is waiting.
    applyStimulus();
    runTo(8);  demand4 = 4'b1000;
    runTo(20); checkOutput("skipYellow", lights4, 8'h41);
    runTo(24); checkOutput("skipDir", activeDir4, 3);
    checkOutput("skipGreen", lights4, 8'h80);
    demand4 = 4'b0000;

    // Green extension on own demand, then rotation once demand drops.
    applyStimulus();
    runTo(8);  demand4 = 4'b0001;
    runTo(20); checkOutput("ext1", lights4, 8'h02);
    runTo(21); checkOutput("ext1Hold", lights4, 8'h02);
    runTo(32); checkOutput("ext2", lights4, 8'h02);
    runTo(36); demand4 = 4'b0000;
    runTo(44); checkOutput("extEndYellow", lights4, 8'h05);
    runTo(48); checkOutput("extEndDir", activeDir4, 1);

    // Reset in the middle of a yellow phase.
    applyStimulus();
    runTo(21); checkOutput("preRstYellow", lights4, 8'h05);
    applyStimulus();
    checkOutput("midRstLights", lights4, 8'h55);
    checkOutput("midRstDir", activeDir4, 0);
    checkOutput("midRstTick0", secTick4, 0);
    runTo(1);  checkOutput("midRstTick1", secTick4, 0);
    runTo(2);  checkOutput("midRstTick2", secTick4, 0);
    runTo(3);  checkOutput("midRstTick3", secTick4, 1);

`ifdef TRAFFIC_PED_EN
    // Pedestrian request during green inserts an all-red walk phase.
    applyStimulus();
    checkOutput("pedRstWalk", walk4, 0);
    runTo(10); pedReq4 = 1'b1;
    runTo(11); pedReq4 = 1'b0;
    runTo(23); checkOutput("pedYellow", lights4, 8'h05);
    runTo(24); checkOutput("walkLights", lights4, 8'h00);
    checkOutput("walkOn", walk4, 1);
    runTo(31); checkOutput("walkLast", walk4, 1);
    runTo(32); checkOutput("walkOff", walk4, 0);
    checkOutput("walkGreen1", lights4, 8'h08);
    checkOutput("walkDir1", activeDir4, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_nway.md
Name: traffic_ctrl_nway

Overview:
- Parametrised N-way intersection light controller; successor to the fixed 4-way, fixed-timing controller.
- Adds configurable direction count and phase durations, an integrated seconds prescaler, and demand-driven direction skipping and green extension.
- Sits at the top of the traffic datapath, driving per-direction 2-bit lamp codes (red=00, yellow=01, green=10).

Parameters:
- NUM_DIR, 4, number of approach directions (2..8).
- CLK_DIV, 50000000, clk cycles per one-second tick.
- STARTUP_SEC, 1, all-yellow startup phase length in ticks.
- GREEN_SEC, 5, green phase length in ticks.
- YELLOW_SEC, 1, yellow handover phase length in ticks.
- WALK_SEC, 4, pedestrian all-red phase length in ticks; used only with PED_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- demand  in  NUM_DIR  per-direction vehicle-present flags, level-sensitive.
- lights  out  2*NUM_DIR  lamp codes; direction d occupies bits [2d+1:2d].
- active_dir  out  $clog2(NUM_DIR)  direction currently owning green/yellow.
- sec_tick  out  1  one-cycle pulse per prescaler wrap.
- ped_req  in  1  pedestrian button pulse; present only with PED_EN.
- walk  out  1  walk lamp; present only with PED_EN.

Behaviour:
- Reset (sampled on posedge clk):
  - state=STARTUP, active_dir=0, next_dir=0, phase counter=0, prescaler=0.
  - lights=all 01, sec_tick=0, walk=0.
  - Reset mid-phase aborts the phase immediately.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - sec_tick=1 for exactly the cycle in which the count equals CLK_DIV-1.
  - The first tick falls CLK_DIV cycles after reset deasserts.
- Phase counter: 8-bit, advances only on sec_tick. A phase ends on the tick where count==DUR-1, then the counter clears. A DUR of 0 behaves as 1.
- State and lights change on the clock edge that samples the ending tick. lights is a registered decode of state, so there is no extra latency.
- STARTUP: all lights yellow. On end, go to GREEN with active_dir=0.
- GREEN: lights[active_dir]=green, all others red. On end, sample demand and pick one of:
  - If any direction other than active_dir has demand: next_dir = first demanding direction searching round-robin from active_dir+1 (wrapping), then go to YELLOW.
  - Else if demand[active_dir]=1: stay in GREEN (extension) with the counter restarted.
  - Else (no demand anywhere): next_dir=(active_dir+1) mod NUM_DIR, then go to YELLOW.
- YELLOW: lights[active_dir] and lights[next_dir] are yellow, all others red. On end, active_dir<=next_dir and go to GREEN.
- The mod-NUM_DIR wrap must be correct for NUM_DIR values that are not powers of two.
- Illegal state encoding: lights all red for one cycle, then STARTUP with active_dir=0.
- demand changes outside the GREEN-ending cycle have no effect.

Optional Feature:
- Macro: TRAFFIC_PED_EN.
- With the macro defined:
  - ped_req sets a sticky ped_pending flag.
  - When a YELLOW phase ends with ped_pending=1, the FSM enters WALK instead of GREEN: all lights red, walk=1, ped_pending cleared on entry.
  - WALK lasts WALK_SEC ticks, then goes to GREEN for next_dir.
  - A ped_req during WALK re-arms ped_pending for the next handover.
  - A ped_req coinciding with the WALK-entry edge stays pending.
- Without the macro: ped_req and walk ports are absent, and the WALK state is not synthesised.

Decomposition:
- Package traffic_pkg holds:
  - lamp code constants LAMP_RED, LAMP_YELLOW, LAMP_GREEN;
  - state typedef (STARTUP, GREEN, YELLOW, WALK);
  - phase counter width constant PH_W=8.
- One sub-module, sec_tick_gen: the CLK_DIV prescaler, instantiated once, producing sec_tick.

Test Plan:
All scenarios use NUM_DIR=4, CLK_DIV=4, STARTUP_SEC=2, GREEN_SEC=3, YELLOW_SEC=1, WALK_SEC=2.
- Reset then demand=0000 -> lights=01010101 for 8 cycles; then dir0 green (lights=00000010) for 12 cycles; then dirs 0 and 1 yellow (00000101) for 4 cycles; then dir1 green.
- demand=1000 held while dir0 is green -> handover yellow on dirs 0 and 3, skipping dirs 1 and 2; then active_dir=3.
- demand=0001 only, while dir0 is green -> green extends in 12-cycle blocks with no yellow; dropping demand mid-green yields rotation to dir1 at the next green end.
- Assert reset for 1 cycle mid-YELLOW -> next cycle lights all 01, active_dir=0, sec_tick stays low for the next 3 cycles.
- Force NUM_DIR=3 with demand=000 -> active_dir sequence 0,1,2,0 with no index 3 ever appearing.
- TRAFFIC_PED_EN build: pulse ped_req during dir0 green -> after the yellow, all red with walk=1 for 8 cycles, then dir1 green and walk=0.
